muldiv_completion_buffer: RTL and testbench

- Receives completed results from the mul/div execution slots: 2 per mul/div unit, even = multiply, odd = divide.
- Queues them in arrival order and drains up to CDB_PORTS per cycle onto the common data bus when downstream is ready.
- Generates the registered `stall` consumed by the mul/div dispatch stage, which then stops issuing new operations.
- Sits between the mul/div execution units and the CDB/ROB writeback arbiter.

---
 rtl/tomasulo_pkg.sv | 18 +
 rtl/mc_pack_compact.sv | 21 ++
 rtl/muldiv_completion_buffer.sv | 122 ++++++++++++
 tb/tb_muldiv_completion_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core types and sizing constants.
// Includes the mul/div completion buffer geometry.
package tomasulo_pkg;

  localparam int no_MulDiv_units = 2;
  localparam int ROB_W           = 5;

  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] ROB_index;
    logic [31:0]      result;
  } ALU_Result_t;

  localparam int MULDIV_CB_DEPTH        = 8;
  localparam int MULDIV_CB_PORTS        = 2;
  localparam int MULDIV_CB_STALL_THRESH = 4 * no_MulDiv_units;

endpackage

// File: rtl/mc_pack_compact.sv
// Prefix-sum compactor: gives each live source its write offset
// among this cycle's live sources, plus the total live count.
module mc_pack_compact #(
  parameter int NUM_SRC = 4,
  parameter int OFF_W   = $clog2(NUM_SRC) + 1
) (
  input  logic [NUM_SRC-1:0]            live,
  output logic [NUM_SRC-1:0][OFF_W-1:0] offset,
  output logic [OFF_W-1:0]              total
);

  always_comb begin
    total  = '0;
    offset = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      offset[i] = total;
      total     = total + OFF_W'(live[i]);
    end
  end

endmodule

// File: rtl/muldiv_completion_buffer.sv
// In-order completion FIFO between the mul/div slots and the CDB.
// Drains up to CDB_PORTS per cycle and produces a registered dispatch stall.
module muldiv_completion_buffer
  import tomasulo_pkg::*;
#(
  parameter int NUM_SRC      = 2 * no_MulDiv_units,
  parameter int DEPTH        = MULDIV_CB_DEPTH,
  parameter int CDB_PORTS    = MULDIV_CB_PORTS,
  parameter int STALL_THRESH = 2 * NUM_SRC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  ALU_Result_t              muldiv_res [NUM_SRC],
  input  logic                     cdb_ready,
  output ALU_Result_t              cdb_out [CDB_PORTS],
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = $clog2(NUM_SRC) + 1;

  ALU_Result_t mem [DEPTH];

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic             stall_reg;
  logic             overflow_reg;

  logic [NUM_SRC-1:0]            live;
  logic [NUM_SRC-1:0][OFF_W-1:0] offset;
  logic [OFF_W-1:0]              live_total;
  logic [NUM_SRC-1:0]            wr_en;
  logic [PTR_W-1:0]              wr_addr [NUM_SRC];

  int   drain_n;
  int   free_n;
  int   enq_n;
  int   count_next;
  logic drop;
  logic stall_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign live[gi] = muldiv_res[gi].valid;
      // Arrivals beyond the free space are the highest-indexed ones and get dropped.
      assign wr_en[gi]   = live[gi] && !flush && (int'(offset[gi]) < free_n);
      assign wr_addr[gi] = tail_reg + PTR_W'(offset[gi]);
    end
  endgenerate

  mc_pack_compact #(
    .NUM_SRC (NUM_SRC),
    .OFF_W   (OFF_W)
  ) u_pack (
    .live   (live),
    .offset (offset),
    .total  (live_total)
  );

  always_comb begin
    drain_n = 0;
    if (cdb_ready) begin
      drain_n = (int'(count_reg) < CDB_PORTS) ? int'(count_reg) : CDB_PORTS;
    end
    free_n     = DEPTH - int'(count_reg) + drain_n;
    enq_n      = (int'(live_total) < free_n) ? int'(live_total) : free_n;
    drop       = int'(live_total) > free_n;
    count_next = int'(count_reg) + enq_n - drain_n;
    stall_next = (DEPTH - count_next) < STALL_THRESH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      stall_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      stall_reg <= 1'b0;
    end else begin
      head_reg  <= head_reg + PTR_W'(drain_n);
      tail_reg  <= tail_reg + PTR_W'(enq_n);
      count_reg <= CNT_W'(count_next);
      stall_reg <= stall_next;
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Storage carries no reset; validity comes solely from count_reg.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (wr_en[i]) begin
        mem[wr_addr[i]] <= muldiv_res[i];
      end
    end
  end

  generate
    for (gi = 0; gi < CDB_PORTS; gi++) begin : g_out
      logic [PTR_W-1:0] rd_addr;
      assign rd_addr     = head_reg + PTR_W'(gi);
      assign cdb_out[gi] = (count_reg > CNT_W'(gi)) ? mem[rd_addr] : '0;
    end
  endgenerate

  assign stall        = stall_reg;
  assign occupancy    = count_reg;
  assign overflow_err = overflow_reg;

endmodule

// File: tb/tb_muldiv_completion_buffer.sv
// Randomized scoreboard bench for the mul/div completion buffer.
// The driver predicts FIFO contents; the monitor compares after each edge.
module tb_muldiv_completion_buffer;
  import tomasulo_pkg::*;

  localparam int NSRC   = 2 * no_MulDiv_units;
  localparam int DEPTH  = 8;
  localparam int PORTS  = 2;
  localparam int THRESH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  ALU_Result_t muldiv_res [NSRC];
  logic        cdb_ready;
  ALU_Result_t cdb_out [PORTS];
  logic        stall;
  logic [3:0]  occupancy;
  logic        overflow_err;

  muldiv_completion_buffer #(
    .NUM_SRC      (NSRC),
    .DEPTH        (DEPTH),
    .CDB_PORTS    (PORTS),
    .STALL_THRESH (THRESH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .muldiv_res   (muldiv_res),
    .cdb_ready    (cdb_ready),
    .cdb_out      (cdb_out),
    .stall        (stall),
    .occupancy    (occupancy),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   drain;
    logic fl;
    logic drop;
  } event_t;

  ALU_Result_t exp_q [$];
  event_t      ev_q [$];
  ALU_Result_t stim [NSRC];
  int          model_cnt = 0;
  logic        exp_ovf   = 1'b0;
  int          n_pass    = 0;
  int          n_total   = 0;
  int          cyc       = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NSRC; i++) begin
      stim[i].valid     = 1'b0;
      stim[i].ROB_index = ROB_W'($urandom);
      stim[i].result    = $urandom;
    end
  endtask

  task automatic set_src(input int i, input int rob, input logic [31:0] data);
    stim[i].valid     = 1'b1;
    stim[i].ROB_index = ROB_W'(rob);
    stim[i].result    = data;
  endtask

  task automatic rand_stim(input int pct_live);
    clear_stim();
    for (int i = 0; i < NSRC; i++)
      if ($urandom_range(99) < pct_live) set_src(i, int'($urandom_range(31)), $urandom);
  endtask

  // One clock of stimulus; the model decides what the buffer holds after the next edge.
  task automatic step(input logic rdy, input logic fl);
    event_t ev;
    int     free_n;
    int     kept;
    @(negedge clk);
    cyc++;
    cdb_ready = rdy;
    flush     = fl;
    for (int i = 0; i < NSRC; i++) muldiv_res[i] = stim[i];
    ev.fl    = fl;
    ev.drop  = 1'b0;
    ev.drain = rdy ? ((model_cnt < PORTS) ? model_cnt : PORTS) : 0;
    if (fl) begin
      model_cnt = 0;
    end else begin
      free_n = DEPTH - model_cnt + ev.drain;
      kept   = 0;
      for (int i = 0; i < NSRC; i++) begin
        if (stim[i].valid) begin
          if (kept < free_n) begin
            exp_q.push_back(stim[i]);
            kept++;
          end else begin
            ev.drop = 1'b1;
          end
        end
      end
      model_cnt = model_cnt + kept - ev.drain;
    end
    ev_q.push_back(ev);
    $display("cyc %0d rdy=%0b flush=%0b live=%0b%0b%0b%0b model_cnt=%0d drop=%0b",
             cyc, rdy, fl, stim[3].valid, stim[2].valid, stim[1].valid, stim[0].valid,
             model_cnt, ev.drop);
    clear_stim();
  endtask

  // Monitor: applies the edge's drain/flush to the scoreboard, then compares.
  initial begin
    event_t ev;
    ALU_Result_t exp_e;
    forever begin
      @(posedge clk);
      #1;
      if (ev_q.size() > 0) begin
        ev = ev_q.pop_front();
        if (ev.fl) exp_q.delete();
        else repeat (ev.drain) void'(exp_q.pop_front());
        if (ev.drop) exp_ovf = 1'b1;
        for (int k = 0; k < PORTS; k++) begin
          if (k < exp_q.size()) begin
            exp_e       = exp_q[k];
            exp_e.valid = 1'b1;
          end else begin
            exp_e = '0;
          end
          chk($sformatf("cdb_out[%0d]", k), 64'(cdb_out[k]), 64'(exp_e));
        end
        chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
        chk("stall", 64'(stall), 64'((DEPTH - exp_q.size()) < THRESH));
        chk("overflow_err", 64'(overflow_err), 64'(exp_ovf));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    cdb_ready = 1'b0;
    flush     = 1'b0;
    clear_stim();
    for (int i = 0; i < NSRC; i++) muldiv_res[i] = stim[i];
    exp_q.delete();
    ev_q.delete();
    model_cnt = 0;
    exp_ovf   = 1'b0;
    #1;
    chk("rst cdb_out[0].valid", 64'(cdb_out[0].valid), 64'(0));
    chk("rst cdb_out[1].valid", 64'(cdb_out[1].valid), 64'(0));
    chk("rst occupancy", 64'(occupancy), 64'(0));
    chk("rst stall", 64'(stall), 64'(0));
    chk("rst overflow_err", 64'(overflow_err), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cdb_ready = 1'b0;
    flush = 1'b0;
    clear_stim();
    for (int i = 0; i < NSRC; i++) muldiv_res[i] = stim[i];
    do_reset();
    step(1, 0); step(1, 0);

    // Single result on source 1.
    set_src(1, 7, 32'h0000_002A); step(1, 0);
    step(1, 0); step(1, 0);

    // Sparse sources 0 and 3 compact into adjacent entries.
    set_src(0, 4, 32'h1111_0004); set_src(3, 2, 32'h3333_0002); step(0, 0);
    step(0, 0); step(1, 0); step(1, 0);

    // Fill towards full while stalled, then full with simultaneous drain/enqueue.
    for (int n = 0; n < 4; n++) begin
      set_src(0, 8 + 2 * n, $urandom); set_src(2, 9 + 2 * n, $urandom); step(0, 0);
    end
    set_src(1, 20, $urandom); set_src(3, 21, $urandom); step(1, 0);
    set_src(0, 22, $urandom); set_src(1, 23, $urandom); step(1, 0);
    repeat (5) step(1, 0);

    // Overflow at count 7, then flush with arrivals.
    for (int i = 0; i < 4; i++) set_src(i, i, $urandom);
    step(0, 0);
    for (int i = 0; i < 3; i++) set_src(i, 10 + i, $urandom);
    step(0, 0);
    for (int i = 1; i < 4; i++) set_src(i, 20 + i, $urandom);
    step(0, 0);
    set_src(0, 30, $urandom); set_src(2, 31, $urandom); step(1, 1);
    step(1, 0); step(0, 0);

    // Reset in the middle of operation with five entries held.
    for (int i = 0; i < 4; i++) set_src(i, 5 + i, $urandom);
    step(0, 0);
    set_src(2, 9, $urandom); step(0, 0);
    @(posedge clk); #2;
    do_reset();
    step(1, 0); step(1, 0);

    // Randomized traffic with occasional flushes.
    for (int n = 0; n < 600; n++) begin
      rand_stim((n % 200 < 100) ? 60 : 25);
      step(($urandom_range(99) < 55) ? 1'b1 : 1'b0, ($urandom_range(59) == 0) ? 1'b1 : 1'b0);
    end
    repeat (6) step(1, 0);
    @(posedge clk); #3;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
